// File: rtl/id_ex_if.sv
// ID/EX boundary bundle: decode-side fields, pipeline control, forwarding
// producers and the EX-side results presented to the ALU.
interface id_ex_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4
);
    logic                  ID_Valid;
    logic [DATA_W-1:0]     ID_Op1;
    logic [DATA_W-1:0]     ID_Op2;
    logic [DATA_W-1:0]     ID_Imm;
    logic                  ID_isImmediate;
    logic [21:9]           ID_ALU_Signals;
    logic [REG_ADDR_W-1:0] ID_Rs1;
    logic [REG_ADDR_W-1:0] ID_Rs2;
    logic                  ID_useRs1;
    logic                  ID_useRs2;
    logic [REG_ADDR_W-1:0] ID_Rd;
    logic                  ID_isWb;
    logic                  ID_isLd;
    logic                  ID_isSt;

    logic                  Stall;
    logic                  Flush;

    logic                  MEM_Fwd_Valid;
    logic [REG_ADDR_W-1:0] MEM_Fwd_Rd;
    logic [DATA_W-1:0]     MEM_Fwd_Data;
    logic                  WB_Fwd_Valid;
    logic [REG_ADDR_W-1:0] WB_Fwd_Rd;
    logic [DATA_W-1:0]     WB_Fwd_Data;

    logic                  EX_Valid;
    logic [DATA_W-1:0]     Operand_EX_A;
    logic [DATA_W-1:0]     Operand_EX_B;
    logic [21:9]           ALU_Signals;
    logic [DATA_W-1:0]     EX_StoreData;
    logic [REG_ADDR_W-1:0] EX_Rd;
    logic                  EX_isWb;
    logic                  EX_isLd;
    logic                  EX_isSt;
    logic                  Hazard_Stall;

    modport master (
        output ID_Valid, ID_Op1, ID_Op2, ID_Imm, ID_isImmediate,
        output ID_ALU_Signals, ID_Rs1, ID_Rs2, ID_useRs1, ID_useRs2,
        output ID_Rd, ID_isWb, ID_isLd, ID_isSt,
        output Stall, Flush,
        output MEM_Fwd_Valid, MEM_Fwd_Rd, MEM_Fwd_Data,
        output WB_Fwd_Valid, WB_Fwd_Rd, WB_Fwd_Data,
        input  EX_Valid, Operand_EX_A, Operand_EX_B, ALU_Signals,
        input  EX_StoreData, EX_Rd, EX_isWb, EX_isLd, EX_isSt,
        input  Hazard_Stall
    );

    modport slave (
        input  ID_Valid, ID_Op1, ID_Op2, ID_Imm, ID_isImmediate,
        input  ID_ALU_Signals, ID_Rs1, ID_Rs2, ID_useRs1, ID_useRs2,
        input  ID_Rd, ID_isWb, ID_isLd, ID_isSt,
        input  Stall, Flush,
        input  MEM_Fwd_Valid, MEM_Fwd_Rd, MEM_Fwd_Data,
        input  WB_Fwd_Valid, WB_Fwd_Rd, WB_Fwd_Data,
        output EX_Valid, Operand_EX_A, Operand_EX_B, ALU_Signals,
        output EX_StoreData, EX_Rd, EX_isWb, EX_isLd, EX_isSt,
        output Hazard_Stall
    );
endinterface

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with MEM/WB operand forwarding, stall, flush
// and load-use bubble insertion.
module id_ex_pipeline_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4
) (
    input logic  clk,
    input logic  reset_n,
    id_ex_if.slave bus
);

    typedef struct packed {
        logic                  valid;
        logic [DATA_W-1:0]     op1;
        logic [DATA_W-1:0]     op2;
        logic [DATA_W-1:0]     imm;
        logic                  is_imm;
        logic [21:9]           alu;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  use1;
        logic                  use2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  is_wb;
        logic                  is_ld;
        logic                  is_st;
    } slot_t;

    slot_t slot_q;
    slot_t slot_d;
    slot_t id_slot;

    logic              fwd_en1;
    logic              fwd_en2;
    logic              m_hit1;
    logic              w_hit1;
    logic              m_hit2;
    logic              w_hit2;
    logic [DATA_W-1:0] fwd1;
    logic [DATA_W-1:0] fwd2;

    logic              rs1_dep;
    logic              rs2_dep;
    logic              hazard;
    logic              kill;

    // Forwarding only applies to sources the live EX instruction reads.
    assign fwd_en1 = slot_q.valid & slot_q.use1;
    assign fwd_en2 = slot_q.valid & slot_q.use2;

    assign m_hit1 = fwd_en1 & bus.MEM_Fwd_Valid
                  & (bus.MEM_Fwd_Rd == slot_q.rs1);
    assign w_hit1 = fwd_en1 & bus.WB_Fwd_Valid
                  & (bus.WB_Fwd_Rd == slot_q.rs1);
    assign m_hit2 = fwd_en2 & bus.MEM_Fwd_Valid
                  & (bus.MEM_Fwd_Rd == slot_q.rs2);
    assign w_hit2 = fwd_en2 & bus.WB_Fwd_Valid
                  & (bus.WB_Fwd_Rd == slot_q.rs2);

    assign fwd1 = m_hit1 ? bus.MEM_Fwd_Data :
                  w_hit1 ? bus.WB_Fwd_Data  :
                           slot_q.op1;
    assign fwd2 = m_hit2 ? bus.MEM_Fwd_Data :
                  w_hit2 ? bus.WB_Fwd_Data  :
                           slot_q.op2;

    assign rs1_dep = bus.ID_useRs1 & (bus.ID_Rs1 == slot_q.rd);
    assign rs2_dep = bus.ID_useRs2 & (bus.ID_Rs2 == slot_q.rd);

    assign hazard = slot_q.valid & slot_q.is_ld & slot_q.is_wb
                  & bus.ID_Valid & (rs1_dep | rs2_dep);

    always_comb begin
        id_slot        = '0;
        id_slot.valid  = bus.ID_Valid;
        id_slot.op1    = bus.ID_Op1;
        id_slot.op2    = bus.ID_Op2;
        id_slot.imm    = bus.ID_Imm;
        id_slot.is_imm = bus.ID_isImmediate;
        id_slot.alu    = bus.ID_ALU_Signals;
        id_slot.rs1    = bus.ID_Rs1;
        id_slot.rs2    = bus.ID_Rs2;
        id_slot.use1   = bus.ID_useRs1;
        id_slot.use2   = bus.ID_useRs2;
        id_slot.rd     = bus.ID_Rd;
        id_slot.is_wb  = bus.ID_isWb;
        id_slot.is_ld  = bus.ID_isLd;
        id_slot.is_st  = bus.ID_isSt;
    end

    // Flush always kills; a load-use bubble only when not stalled.
    assign kill = bus.Flush | (~bus.Stall & hazard);

    always_comb begin
        slot_d = slot_q;
        if (kill) begin
            slot_d.valid = 1'b0;
            slot_d.alu   = '0;
            slot_d.is_wb = 1'b0;
            slot_d.is_ld = 1'b0;
            slot_d.is_st = 1'b0;
        end else if (bus.Stall) begin
            // Keep a producer that retires during the stall.
            slot_d.op1 = fwd1;
            slot_d.op2 = fwd2;
        end else begin
            slot_d = id_slot;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign bus.EX_Valid     = slot_q.valid;
    assign bus.Operand_EX_A = fwd1;
    assign bus.Operand_EX_B = slot_q.is_imm ? slot_q.imm : fwd2;
    assign bus.ALU_Signals  = slot_q.alu;
    assign bus.EX_StoreData = fwd2;
    assign bus.EX_Rd        = slot_q.rd;
    assign bus.EX_isWb      = slot_q.is_wb;
    assign bus.EX_isLd      = slot_q.is_ld;
    assign bus.EX_isSt      = slot_q.is_st;
    assign bus.Hazard_Stall = hazard;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Bench for id_ex_pipeline_reg: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a slot-level model.
module tb_id_ex_pipeline_reg;

  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus ();

  id_ex_pipeline_reg #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the instruction currently sitting in EX.
  typedef struct {
    bit          v;
    logic [31:0] op1, op2, imm;
    bit          isimm;
    logic [12:0] alu;
    logic [3:0]  rs1, rs2, rd;
    bit          u1, u2, wb, ld, st;
  } slot_t;

  slot_t m;

  function automatic logic [31:0] mfwd(bit u, logic [3:0] rs,
                                       logic [31:0] held);
    if (m.v && u && bus.MEM_Fwd_Valid && bus.MEM_Fwd_Rd == rs)
      return bus.MEM_Fwd_Data;
    if (m.v && u && bus.WB_Fwd_Valid && bus.WB_Fwd_Rd == rs)
      return bus.WB_Fwd_Data;
    return held;
  endfunction

  function automatic bit mhaz();
    bit dep;
    dep = (bus.ID_useRs1 && bus.ID_Rs1 == m.rd)
       || (bus.ID_useRs2 && bus.ID_Rs2 == m.rd);
    return m.v && m.ld && m.wb && bus.ID_Valid && dep;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m <= '{default: 0};
    end else if (bus.Flush || (!bus.Stall && mhaz())) begin
      m.v   <= 1'b0;
      m.alu <= '0;
      m.wb  <= 1'b0;
      m.ld  <= 1'b0;
      m.st  <= 1'b0;
    end else if (bus.Stall) begin
      m.op1 <= mfwd(m.u1, m.rs1, m.op1);
      m.op2 <= mfwd(m.u2, m.rs2, m.op2);
    end else begin
      m <= '{v: bus.ID_Valid, op1: bus.ID_Op1, op2: bus.ID_Op2,
             imm: bus.ID_Imm, isimm: bus.ID_isImmediate,
             alu: bus.ID_ALU_Signals, rs1: bus.ID_Rs1,
             rs2: bus.ID_Rs2, rd: bus.ID_Rd, u1: bus.ID_useRs1,
             u2: bus.ID_useRs2, wb: bus.ID_isWb, ld: bus.ID_isLd,
             st: bus.ID_isSt};
    end
  end

  always @(negedge clk) begin
    logic [31:0] eb;
    chk("m_valid", bus.EX_Valid, m.v);
    chk("m_alu", bus.ALU_Signals, m.alu);
    chk("m_wb", bus.EX_isWb, m.wb);
    chk("m_ld", bus.EX_isLd, m.ld);
    chk("m_st", bus.EX_isSt, m.st);
    chk("m_hazard", bus.Hazard_Stall, mhaz());
    if (m.v) begin
      eb = m.isimm ? m.imm : mfwd(m.u2, m.rs2, m.op2);
      chk("m_opA", bus.Operand_EX_A, mfwd(m.u1, m.rs1, m.op1));
      chk("m_opB", bus.Operand_EX_B, eb);
      chk("m_store", bus.EX_StoreData, mfwd(m.u2, m.rs2, m.op2));
      chk("m_rd", bus.EX_Rd, m.rd);
    end
  end

  task automatic idle();
    bus.ID_Valid       = 0;
    bus.ID_Op1         = '0;
    bus.ID_Op2         = '0;
    bus.ID_Imm         = '0;
    bus.ID_isImmediate = 0;
    bus.ID_ALU_Signals = '0;
    bus.ID_Rs1         = '0;
    bus.ID_Rs2         = '0;
    bus.ID_useRs1      = 0;
    bus.ID_useRs2      = 0;
    bus.ID_Rd          = '0;
    bus.ID_isWb        = 0;
    bus.ID_isLd        = 0;
    bus.ID_isSt        = 0;
    bus.Stall          = 0;
    bus.Flush          = 0;
    bus.MEM_Fwd_Valid  = 0;
    bus.MEM_Fwd_Rd     = '0;
    bus.MEM_Fwd_Data   = '0;
    bus.WB_Fwd_Valid   = 0;
    bus.WB_Fwd_Rd      = '0;
    bus.WB_Fwd_Data    = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  localparam logic [12:0] ADD = 13'h0001;

  initial begin
    idle();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1;
    #1;
    chk("rst_valid", bus.EX_Valid, 0);
    chk("rst_alu", bus.ALU_Signals, 0);
    chk("rst_a", bus.Operand_EX_A, 0);
    chk("rst_b", bus.Operand_EX_B, 0);
    chk("rst_haz", bus.Hazard_Stall, 0);

    // add with immediate
    cyc();
    bus.ID_Valid = 1; bus.ID_Op1 = 5; bus.ID_Imm = 7;
    bus.ID_isImmediate = 1; bus.ID_ALU_Signals = ADD;
    cyc();
    idle();
    #1;
    chk("t2_a", bus.Operand_EX_A, 5);
    chk("t2_b", bus.Operand_EX_B, 7);
    chk("t2_alu9", bus.ALU_Signals[9], 1);
    chk("t2_valid", bus.EX_Valid, 1);

    // MEM beats WB
    bus.ID_Valid = 1; bus.ID_Rs1 = 3; bus.ID_useRs1 = 1;
    bus.ID_Op1 = 32'h11; bus.ID_ALU_Signals = ADD;
    cyc();
    idle();
    bus.MEM_Fwd_Valid = 1; bus.MEM_Fwd_Rd = 3; bus.MEM_Fwd_Data = 32'hAA;
    bus.WB_Fwd_Valid = 1; bus.WB_Fwd_Rd = 3; bus.WB_Fwd_Data = 32'hBB;
    #1;
    chk("t3_mem", bus.Operand_EX_A, 32'hAA);
    bus.MEM_Fwd_Valid = 0;
    #1;
    chk("t3_wb", bus.Operand_EX_A, 32'hBB);

    // load-use bubble
    cyc();
    idle();
    bus.ID_Valid = 1; bus.ID_isLd = 1; bus.ID_isWb = 1; bus.ID_Rd = 4;
    cyc();
    idle();
    bus.ID_Valid = 1; bus.ID_useRs1 = 1; bus.ID_Rs1 = 4;
    bus.ID_Op1 = 32'hDEAD; bus.ID_ALU_Signals = ADD; bus.ID_Rd = 5;
    #1;
    chk("t4_haz", bus.Hazard_Stall, 1);
    cyc();
    #1;
    chk("t4_bub_valid", bus.EX_Valid, 0);
    chk("t4_bub_alu", bus.ALU_Signals, 0);
    chk("t4_bub_haz", bus.Hazard_Stall, 0);
    cyc();
    idle();
    bus.WB_Fwd_Valid = 1; bus.WB_Fwd_Rd = 4; bus.WB_Fwd_Data = 32'h1234;
    #1;
    chk("t4_valid", bus.EX_Valid, 1);
    chk("t4_fwd", bus.Operand_EX_A, 32'h1234);
    chk("t4_alu", bus.ALU_Signals, ADD);

    // stall keeps a producer seen only in its first cycle
    cyc();
    idle();
    bus.ID_Valid = 1; bus.ID_useRs2 = 1; bus.ID_Rs2 = 6;
    bus.ID_Op2 = 32'h0; bus.ID_isSt = 1;
    cyc();
    idle();
    bus.Stall = 1;
    bus.WB_Fwd_Valid = 1; bus.WB_Fwd_Rd = 6; bus.WB_Fwd_Data = 32'h55;
    cyc();
    bus.WB_Fwd_Valid = 0;
    cyc();
    cyc();
    bus.Stall = 0;
    #1;
    chk("t5_b", bus.Operand_EX_B, 32'h55);
    chk("t5_sd", bus.EX_StoreData, 32'h55);
    chk("t5_valid", bus.EX_Valid, 1);

    // flush beats stall
    cyc();
    idle();
    bus.ID_Valid = 1; bus.ID_ALU_Signals = ADD; bus.ID_isWb = 1;
    cyc();
    idle();
    bus.Stall = 1; bus.Flush = 1;
    cyc();
    idle();
    #1;
    chk("t6_valid", bus.EX_Valid, 0);
    chk("t6_alu", bus.ALU_Signals, 0);
    chk("t6_wb", bus.EX_isWb, 0);

    // asynchronous reset mid-run
    bus.ID_Valid = 1; bus.ID_ALU_Signals = ADD; bus.ID_Op1 = 32'h99;
    cyc();
    idle();
    reset_n = 0;
    #1;
    chk("t1_valid", bus.EX_Valid, 0);
    chk("t1_alu", bus.ALU_Signals, 0);
    chk("t1_a", bus.Operand_EX_A, 0);
    cyc();
    reset_n = 1;
    bus.ID_Valid = 1; bus.ID_Op1 = 32'h77; bus.ID_ALU_Signals = ADD;
    #1;
    chk("t1_hold", bus.EX_Valid, 0);
    cyc();
    idle();
    #1;
    chk("t1_valid2", bus.EX_Valid, 1);
    chk("t1_a2", bus.Operand_EX_A, 32'h77);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc();
      reset_n = ($urandom_range(0, 599) != 0);
      bus.ID_Valid       = ($urandom_range(0, 9) < 8);
      bus.ID_Op1         = $urandom;
      bus.ID_Op2         = $urandom;
      bus.ID_Imm         = $urandom;
      bus.ID_isImmediate = $urandom_range(0, 1);
      bus.ID_ALU_Signals = ($urandom_range(0, 7) == 0) ? 13'h0 :
                           13'(1 << $urandom_range(0, 12));
      bus.ID_Rs1         = 4'($urandom_range(0, 3));
      bus.ID_Rs2         = 4'($urandom_range(0, 3));
      bus.ID_useRs1      = $urandom_range(0, 1);
      bus.ID_useRs2      = $urandom_range(0, 1);
      bus.ID_Rd          = 4'($urandom_range(0, 3));
      bus.ID_isLd        = ($urandom_range(0, 2) == 0);
      bus.ID_isWb        = ($urandom_range(0, 3) != 0);
      bus.ID_isSt        = $urandom_range(0, 1);
      bus.Stall          = ($urandom_range(0, 3) == 0);
      bus.Flush          = ($urandom_range(0, 9) == 0);
      bus.MEM_Fwd_Valid  = $urandom_range(0, 1);
      bus.MEM_Fwd_Rd     = 4'($urandom_range(0, 3));
      bus.MEM_Fwd_Data   = $urandom;
      bus.WB_Fwd_Valid   = $urandom_range(0, 1);
      bus.WB_Fwd_Rd      = 4'($urandom_range(0, 3));
      bus.WB_Fwd_Data    = $urandom;
    end

    cyc();
    reset_n = 1;
    idle();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
